anim_palette: RTL and testbench

ANIM_PALETTE -- requirements
Module: anim_palette

---
 rtl/anim_palette.sv | 167 ++++++++++++++++
 tb/tb_anim_palette.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/anim_palette.sv
// anim_palette: 12-bit RGB palette with NUM_PORTS concurrent lookup ports,
// optional colour-cycling (palette rotation) and per-port highlight.
// Optional feature macro: ANIM_PALETTE_CYCLE_EN builds the rotation logic
// (frame counter, rotation offset, range-change detection). Without it the
// effective index equals the raw index and cycle_*/frame_tick are ignored.
//
// Handshake: there is no backpressure. rd_valid_in[p] qualifies the request
// on port p in the cycle it is presented; rd_valid_out[p] qualifies the
// result exactly one cycle later, and all result fields are 0 when it is low.
module anim_palette #(
  parameter int INDEX_W    = 4,
  parameter int NUM_PORTS  = 2,
  parameter int CYCLE_DIV  = 8,
  parameter int TRANSP_IDX = 0
) (
  input  logic                           Clk,
  input  logic                           reset_n,
  input  logic                           frame_tick,
  input  logic                           wr_en,
  input  logic [INDEX_W-1:0]             wr_addr,
  input  logic [11:0]                    wr_data,
  input  logic                           cycle_en,
  input  logic [INDEX_W-1:0]             cycle_lo,
  input  logic [INDEX_W-1:0]             cycle_hi,
  input  logic [NUM_PORTS*INDEX_W-1:0]   rd_index,
  input  logic [NUM_PORTS-1:0]           rd_valid_in,
  input  logic [NUM_PORTS-1:0]           highlight,
  output logic [NUM_PORTS*4-1:0]         red,
  output logic [NUM_PORTS*4-1:0]         green,
  output logic [NUM_PORTS*4-1:0]         blue,
  output logic [NUM_PORTS-1:0]           rd_valid_out,
  output logic [NUM_PORTS-1:0]           transparent
);

  localparam int DEPTH = 2**INDEX_W;
  localparam int OW    = INDEX_W + 1;

  logic [11:0]                mem_q [DEPTH];
  logic [INDEX_W-1:0]         eff [NUM_PORTS];
  logic [11:0]                rd_data [NUM_PORTS];
  logic [NUM_PORTS-1:0][3:0]  red_q, green_q, blue_q;
  logic [NUM_PORTS-1:0]       valid_q, transp_q;

`ifdef ANIM_PALETTE_CYCLE_EN
  logic [7:0]         fcnt_q, fcnt_d;
  logic [INDEX_W-1:0] offset_q, offset_d;
  logic [INDEX_W-1:0] lo_q, hi_q;
  logic               range_ok;
  logic               range_chg;
  logic [OW-1:0]      range_len;
  logic [INDEX_W-1:0] off_eff;

  assign range_ok  = cycle_en && (cycle_lo <= cycle_hi);
  assign range_chg = (cycle_lo != lo_q) || (cycle_hi != hi_q);
  assign range_len = OW'(cycle_hi) - OW'(cycle_lo) + OW'(1);
  // A range edit invalidates the stored offset immediately, so lookups in
  // that cycle already use offset 0 and never exceed the new range.
  assign off_eff   = range_chg ? '0 : offset_q;

  // Rotation: offset added modulo the range length; offset < length always
  // holds, so one conditional subtraction replaces a divider.
  function automatic logic [INDEX_W-1:0] eff_index(input logic [INDEX_W-1:0] idx);
    logic [OW-1:0] rel;
    rel = OW'(idx) - OW'(cycle_lo) + OW'(off_eff);
    if (rel >= range_len) rel = rel - range_len;
    if (range_ok && (idx >= cycle_lo) && (idx <= cycle_hi))
      eff_index = cycle_lo + rel[INDEX_W-1:0];
    else
      eff_index = idx;
  endfunction

  // Frame counter / offset next state; range edits win over frame_tick.
  always_comb begin
    fcnt_d   = fcnt_q;
    offset_d = offset_q;
    if (!range_ok || range_chg) begin
      fcnt_d   = '0;
      offset_d = '0;
    end else if (frame_tick) begin
      if (fcnt_q == 8'(CYCLE_DIV - 1)) begin
        fcnt_d = '0;
        if (OW'(offset_q) + OW'(1) >= range_len) offset_d = '0;
        else                                     offset_d = offset_q + INDEX_W'(1);
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Rotation state registers and last-seen range for change detection.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      fcnt_q   <= '0;
      offset_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      fcnt_q   <= fcnt_d;
      offset_q <= offset_d;
      lo_q     <= cycle_lo;
      hi_q     <= cycle_hi;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{frame_tick, cycle_en, cycle_lo, cycle_hi};

  function automatic logic [INDEX_W-1:0] eff_index(input logic [INDEX_W-1:0] idx);
    eff_index = idx;
  endfunction
`endif

  // Saturating +4 brighten of one 4-bit channel.
  function automatic logic [3:0] brighten(input logic [3:0] c);
    brighten = (c >= 4'd12) ? 4'hF : c + 4'd4;
  endfunction

  // Palette table: greyscale ramp on reset, single write port otherwise.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {3{4'(i)}};
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational lookup from the pre-write table contents (read-before-write).
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      eff[p]     = eff_index(rd_index[p*INDEX_W +: INDEX_W]);
      rd_data[p] = mem_q[eff[p]];
    end
  end

  // Result registers: one-cycle latency, zeroed when the request is invalid.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      valid_q  <= '0;
      transp_q <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      valid_q <= rd_valid_in;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_valid_in[p]) begin
          transp_q[p] <= (rd_index[p*INDEX_W +: INDEX_W] == INDEX_W'(TRANSP_IDX));
          red_q[p]    <= highlight[p] ? brighten(rd_data[p][11:8]) : rd_data[p][11:8];
          green_q[p]  <= highlight[p] ? brighten(rd_data[p][7:4])  : rd_data[p][7:4];
          blue_q[p]   <= highlight[p] ? brighten(rd_data[p][3:0])  : rd_data[p][3:0];
        end else begin
          transp_q[p] <= 1'b0;
          red_q[p]    <= 4'h0;
          green_q[p]  <= 4'h0;
          blue_q[p]   <= 4'h0;
        end
      end
    end
  end

  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign rd_valid_out = valid_q;
  assign transparent  = transp_q;

endmodule

// File: tb/tb_anim_palette.sv
// Directed bench for anim_palette: reset behaviour, a table of lookup
// vectors against the reset greyscale ramp, and hand-written sequences for
// write/read collision, highlight saturation, reset mid-run and (when
// ANIM_PALETTE_CYCLE_EN is defined) palette rotation.
module tb_anim_palette;

  localparam int INDEX_W    = 4;
  localparam int NUM_PORTS  = 2;
  localparam int CYCLE_DIV  = 2;
  localparam int TRANSP_IDX = 0;

  logic                         Clk = 1'b0;
  logic                         reset_n;
  logic                         frame_tick;
  logic                         wr_en;
  logic [INDEX_W-1:0]           wr_addr;
  logic [11:0]                  wr_data;
  logic                         cycle_en;
  logic [INDEX_W-1:0]           cycle_lo;
  logic [INDEX_W-1:0]           cycle_hi;
  logic [NUM_PORTS*INDEX_W-1:0] rd_index;
  logic [NUM_PORTS-1:0]         rd_valid_in;
  logic [NUM_PORTS-1:0]         highlight;
  logic [NUM_PORTS*4-1:0]       red, green, blue;
  logic [NUM_PORTS-1:0]         rd_valid_out;
  logic [NUM_PORTS-1:0]         transparent;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  anim_palette #(
    .INDEX_W(INDEX_W), .NUM_PORTS(NUM_PORTS),
    .CYCLE_DIV(CYCLE_DIV), .TRANSP_IDX(TRANSP_IDX)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cycle_en(cycle_en), .cycle_lo(cycle_lo), .cycle_hi(cycle_hi),
    .rd_index(rd_index), .rd_valid_in(rd_valid_in), .highlight(highlight),
    .red(red), .green(green), .blue(blue),
    .rd_valid_out(rd_valid_out), .transparent(transparent)
  );

  // Clock
  always #5 Clk = ~Clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_read(input int p, input logic [3:0] idx, input logic v, input logic hl);
    rd_index[p*INDEX_W +: INDEX_W] = idx;
    rd_valid_in[p] = v;
    highlight[p]   = hl;
  endtask

  task automatic idle_reads();
    rd_valid_in = '0;
    highlight   = '0;
    rd_index    = '0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Single read on port p, one cycle later.
  task automatic read1(input int p, input logic [3:0] idx);
    idle_reads();
    drive_read(p, idx, 1'b1, 1'b0);
    step();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_port(input string name, input int p,
                            input logic [11:0] rgb, input logic v, input logic t);
    logic [13:0] act;
    logic [13:0] exp;
    logic [11:0] exp_rgb;
    exp_q.push_back(rgb);
    exp_rgb = exp_q.pop_front();
    act = {rd_valid_out[p], transparent[p], red[p*4 +: 4], green[p*4 +: 4], blue[p*4 +: 4]};
    exp = {v, t, exp_rgb};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port%0d: got v=%b t=%b rgb=%h, expected v=%b t=%b rgb=%h",
               name, p, act[13], act[12], act[11:0], exp[13], exp[12], exp[11:0]);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  idx0; logic v0; logic h0;
    logic [3:0]  idx1; logic v1; logic h1;
    logic [11:0] rgb0; logic ev0; logic et0;
    logic [11:0] rgb1; logic ev1; logic et1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Lookups against the reset ramp (entry i = iii), rotation disabled.
    vecs[0] = '{4'd5,  1, 0, 4'd0,  1, 0, 12'h555, 1, 0, 12'h000, 1, 1};
    vecs[1] = '{4'd9,  1, 1, 4'd0,  0, 0, 12'hDDD, 1, 0, 12'h000, 0, 0};
    vecs[2] = '{4'd15, 1, 1, 4'd12, 1, 1, 12'hFFF, 1, 0, 12'hFFF, 1, 0};
    vecs[3] = '{4'd11, 1, 1, 4'd0,  1, 1, 12'hFFF, 1, 0, 12'h444, 1, 1};
    vecs[4] = '{4'd0,  0, 1, 4'd7,  1, 0, 12'h000, 0, 0, 12'h777, 1, 0};
    vecs[5] = '{4'd3,  1, 0, 4'd3,  1, 0, 12'h333, 1, 0, 12'h333, 1, 0};

    // ---------------- reset ----------------
    reset_n = 1'b0; frame_tick = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 12'h123;
    cycle_en = 1'b0; cycle_lo = '0; cycle_hi = '0;
    idle_reads();
    drive_read(0, 4'd5, 1'b1, 1'b0);
    drive_read(1, 4'd0, 1'b1, 1'b0);
    step();
    step();
    check_port("reset_p0", 0, 12'h000, 1'b0, 1'b0);
    check_port("reset_p1", 1, 12'h000, 1'b0, 1'b0);
    reset_n = 1'b1;
    wr_en = 1'b0;
    idle_reads();
    step();
    check_port("req_in_reset_discarded", 0, 12'h000, 1'b0, 1'b0);
    read1(0, 4'd5);
    check_port("reset_then_read", 0, 12'h555, 1'b1, 1'b0);

    // ---------------- table-driven lookups ----------------
    for (int i = 0; i < 6; i++) begin
      idle_reads();
      drive_read(0, vecs[i].idx0, vecs[i].v0, vecs[i].h0);
      drive_read(1, vecs[i].idx1, vecs[i].v1, vecs[i].h1);
      step();
      check_port($sformatf("vec%0d", i), 0, vecs[i].rgb0, vecs[i].ev0, vecs[i].et0);
      check_port($sformatf("vec%0d", i), 1, vecs[i].rgb1, vecs[i].ev1, vecs[i].et1);
    end

    // ---------------- write/read collision ----------------
    idle_reads();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'hEB4;
    drive_read(1, 4'd3, 1'b1, 1'b0);
    step();
    wr_en = 1'b0;
    check_port("collision_old", 1, 12'h333, 1'b1, 1'b0);
    read1(1, 4'd3);
    check_port("collision_new", 1, 12'hEB4, 1'b1, 1'b0);

    // ---------------- highlight saturation ----------------
    idle_reads();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 12'hD3F;
    step();
    wr_en = 1'b0;
    drive_read(0, 4'd7, 1'b1, 1'b1);
    drive_read(1, 4'd0, 1'b1, 1'b0);
    step();
    check_port("highlight_sat", 0, 12'hF7F, 1'b1, 1'b0);
    check_port("transparent_idx0", 1, 12'h000, 1'b1, 1'b1);

    // ---------------- reset discards written entries ----------------
    idle_reads();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    read1(0, 4'd3);
    check_port("reset_restores_3", 0, 12'h333, 1'b1, 1'b0);
    read1(0, 4'd7);
    check_port("reset_restores_7", 0, 12'h777, 1'b1, 1'b0);

    // ---------------- rotation ----------------
    idle_reads();
    cycle_en = 1'b1; cycle_lo = 4'd2; cycle_hi = 4'd4;
    step();
`ifdef ANIM_PALETTE_CYCLE_EN
    ticks(2);                          // offset 1
    read1(0, 4'd2);
    check_port("rot_off1_idx2", 0, 12'h333, 1'b1, 1'b0);
    read1(0, 4'd4);
    check_port("rot_off1_idx4_wrap", 0, 12'h222, 1'b1, 1'b0);
    read1(1, 4'd5);
    check_port("rot_idx5_untouched", 1, 12'h555, 1'b1, 1'b0);
    ticks(4);                          // 6 ticks: offset wraps to 0
    read1(0, 4'd2);
    check_port("rot_6ticks_wrap", 0, 12'h222, 1'b1, 1'b0);
    ticks(5);                          // offset 2, fcnt 1
    read1(0, 4'd2);
    check_port("rot_off2_idx2", 0, 12'h444, 1'b1, 1'b0);
    // Range change coincident with a tick: clears offset and fcnt.
    idle_reads();
    cycle_hi = 4'd6;
    tick();
    read1(0, 4'd2);
    check_port("range_chg_off0", 0, 12'h222, 1'b1, 1'b0);
    tick();                            // fcnt 0 -> 1, offset stays 0
    read1(0, 4'd2);
    check_port("range_chg_fcnt0", 0, 12'h222, 1'b1, 1'b0);
    tick();                            // offset 1 over range 2..6
    read1(0, 4'd6);
    check_port("rot_new_range_wrap", 0, 12'h222, 1'b1, 1'b0);
    // Reset with offset 1.
    idle_reads();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    read1(0, 4'd2);
    check_port("reset_mid_rotation", 0, 12'h222, 1'b1, 1'b0);
`else
    ticks(4);
    read1(0, 4'd2);
    check_port("no_rotation_idx2", 0, 12'h222, 1'b1, 1'b0);
    read1(1, 4'd4);
    check_port("no_rotation_idx4", 1, 12'h444, 1'b1, 1'b0);
`endif

    // Invalid request after activity returns zeros.
    idle_reads();
    step();
    check_port("idle_zero_p0", 0, 12'h000, 1'b0, 1'b0);
    check_port("idle_zero_p1", 1, 12'h000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
